// File: rtl/ifu_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and instruction memory (slave).
interface ifu_fetch_if;
    logic [31:0] pc;
    logic        arvalid;
    logic        arready;
    logic        rready;
    logic        rvalid;
    logic        rresp;
    logic [31:0] inst;

    modport master (
        output pc, arvalid, rready,
        input  arready, rvalid, rresp, inst
    );

    modport slave (
        input  pc, arvalid, rready,
        output arready, rvalid, rresp, inst
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, runs the memory read handshake and hands one instruction at a time to decode.
// Optional perf counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
`ifdef IFU_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    ifu_fetch_if.master       mem,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc
`ifdef IFU_PERF_CNT_EN
    , output logic [CNT_W-1:0] perf_fetch_cnt
    , output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state;
    logic [31:0] pc_reg;
    logic [31:0] redir_q;
    logic        kill;
    logic        arvalid_q;
    logic        rready_q;

    assign mem.pc      = pc_reg;
    assign mem.arvalid = arvalid_q;
    assign mem.rready  = rready_q;

    // The memory flags every beat as OK, so the response code carries no information.
    logic unused_rresp;
    assign unused_rresp = mem.rresp;

    // Only consumed while kill is set, and kill is only set alongside a write here.
    always_ff @(posedge clk) begin
        if (redirect_valid) begin
            redir_q <= redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc_reg    <= RESET_PC;
            kill      <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            out_valid <= 1'b0;
            out_inst  <= 32'd0;
            out_pc    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc_reg <= redirect_pc;
                    end
                    state     <= S_REQ;
                    arvalid_q <= 1'b1;
                    rready_q  <= 1'b1;
                end
                S_REQ: begin
                    // A redirect here cannot withdraw the request; mark the response as wrong-path instead.
                    if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                    if (mem.arready) begin
                        state     <= S_WAIT;
                        arvalid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem.rvalid) begin
                        kill     <= 1'b0;
                        rready_q <= 1'b0;
                        if (redirect_valid) begin
                            pc_reg    <= redirect_pc;
                            state     <= S_REQ;
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b1;
                        end else if (kill) begin
                            pc_reg    <= redir_q;
                            state     <= S_REQ;
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b1;
                        end else begin
                            out_inst  <= mem.inst;
                            out_pc    <= pc_reg;
                            out_valid <= 1'b1;
                            pc_reg    <= pc_reg + 32'd4;
                            state     <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A redirect drops the held instruction even if decode takes it this cycle.
                    if (redirect_valid || out_ready) begin
                        if (redirect_valid) begin
                            pc_reg <= redirect_pc;
                        end
                        out_valid <= 1'b0;
                        state     <= S_REQ;
                        arvalid_q <= 1'b1;
                        rready_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (out_valid && out_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            end
            if (state == S_REQ || state == S_WAIT) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small instruction-memory model (inst = ~pc) of configurable latency.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int fails  = 0;
    int lat    = 0;

    ifu_fetch_if bus ();

    ifu_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem            (bus),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt (perf_fetch_cnt)
        , .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    // Memory model: answers lat+1 cycles after an accepted request, driven just after the falling edge.
    initial begin
        int          cnt;
        logic [31:0] pc_lat;
        cnt = 0;
        pc_lat = '0;
        bus.rvalid = 1'b0;
        bus.rresp  = 1'b0;
        bus.inst   = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.rvalid = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (cnt != 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    bus.rvalid = 1'b1;
                    bus.inst   = ~pc_lat;
                end
            end
            if (rst_n && bus.arvalid && bus.arready) begin
                cnt    = 1 + lat;
                pc_lat = bus.pc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input string tag, input logic [31:0] exp_pc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check({tag, " out_valid"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({tag, " out_pc"}, out_pc, exp_pc);
            check({tag, " out_inst"}, out_inst, ~exp_pc);
        end
    endtask

    task automatic wait_ar(input string tag, input logic [31:0] exp_pc);
        logic seen;
        logic saw_ov;
        seen = 1'b0;
        saw_ov = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (out_valid) saw_ov = 1'b1;
            if (bus.arvalid) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, " no out_valid"}, {31'd0, saw_ov}, 32'd0);
        check({tag, " arvalid"}, {31'd0, seen}, 32'd1);
        if (seen) check({tag, " pc"}, bus.pc, exp_pc);
    endtask

    task automatic wait_wait(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (!bus.arvalid && bus.rready) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, " reached WAIT"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.arready    = 1'b1;
        repeat (2) @(negedge clk);

        check("rst arvalid",   {31'd0, bus.arvalid}, 32'd0);
        check("rst rready",    {31'd0, bus.rready}, 32'd0);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_inst",  out_inst, 32'd0);
        check("rst out_pc",    out_pc, 32'd0);
        check("rst pc",        bus.pc, 32'h8000_0000);
        rst_n = 1'b1;

        // Zero-wait stream
        wait_ar("first req", 32'h8000_0000);
        wait_out("seq0", 32'h8000_0000);
        wait_out("seq1", 32'h8000_0004);
        wait_out("seq2", 32'h8000_0008);

        // Decode stall holds the instruction and issues nothing
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall out_valid", {31'd0, out_valid}, 32'd1);
            check("stall out_pc",    out_pc, 32'h8000_0008);
            check("stall out_inst",  out_inst, ~32'h8000_0008);
            check("stall arvalid",   {31'd0, bus.arvalid}, 32'd0);
        end
        out_ready = 1'b1;
        wait_out("resume", 32'h8000_000C);

        // Memory backpressure keeps arvalid and pc steady
        bus.arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp arvalid", {31'd0, bus.arvalid}, 32'd1);
            check("bp pc",      bus.pc, 32'h8000_0010);
        end
        bus.arready = 1'b1;
        wait_out("bp done", 32'h8000_0010);

        // Redirect while waiting on a slow response
        lat = 2;
        wait_wait("redir wait");
        pulse_redirect(32'h8000_0100);
        lat = 0;
        wait_ar("redir wait", 32'h8000_0100);
        wait_out("redir wait tgt", 32'h8000_0100);

        // Redirect coincident with rvalid
        wait_wait("redir rvalid");
        pulse_redirect(32'h8000_0200);
        wait_ar("redir rvalid", 32'h8000_0200);
        wait_out("redir rvalid tgt", 32'h8000_0200);

        // Redirect in HOLD while decode accepts
        pulse_redirect(32'h8000_0300);
        wait_ar("redir hold", 32'h8000_0300);
        wait_out("redir hold tgt", 32'h8000_0300);

        // Redirect in REQ before the address is accepted
        bus.arready = 1'b0;
        @(negedge clk);
        pulse_redirect(32'h8000_0400);
        bus.arready = 1'b1;
        @(negedge clk);
        wait_ar("redir req", 32'h8000_0400);
        wait_out("redir req tgt", 32'h8000_0400);

        // Async reset in the middle of WAIT
        lat = 2;
        wait_wait("reset wait");
        #2 rst_n = 1'b0;
        #1;
        check("mid rst arvalid",   {31'd0, bus.arvalid}, 32'd0);
        check("mid rst rready",    {31'd0, bus.rready}, 32'd0);
        check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        check("mid rst out_inst",  out_inst, 32'd0);
        check("mid rst out_pc",    out_pc, 32'd0);
        check("mid rst pc",        bus.pc, 32'h8000_0000);
        lat = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            wait_out("post rst", 32'h8000_0000 + 32'(4 * i));
        end
        @(negedge clk);
`ifdef IFU_PERF_CNT_EN
        check("perf fetch", perf_fetch_cnt, 32'd10);
        check("perf stall", perf_stall_cnt, 32'd20);
`endif
        wait_out("post rst 10", 32'h8000_0028);

        // PC wraps past the top of the address space
        pulse_redirect(32'hFFFF_FFFC);
        wait_out("wrap top", 32'hFFFF_FFFC);
        wait_out("wrap zero", 32'h0000_0000);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit, directly upstream of the instruction memory.
- Owns the PC register and drives the memory read handshake (pc, arvalid, rready); captures the returned inst.
- Hands each fetched instruction to decode over a registered valid/ready interface.
- Accepts redirects (branch/jump/trap targets) from execute and discards in-flight wrong-path fetches.

Parameters:
- RESET_PC, 32'h8000_0000: PC value loaded on reset.
- CNT_W, 32: width of the perf counters; used only with IFU_PERF_CNT_EN.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc  out  32  fetch address to instruction memory; stable from REQ entry until the response returns
- arvalid  out  1  read address valid
- arready  in  1  read address ready (memory may tie high)
- rready  out  1  read data ready
- rvalid  in  1  read data valid
- rresp  in  1  read response; ignored (memory asserts it with every beat)
- inst  in  32  read data; sampled only when rvalid && rready
- out_valid  out  1  instruction valid to decode (registered)
- out_ready  in  1  decode accepts instruction
- out_inst  out  32  instruction to decode
- out_pc  out  32  PC of out_inst
- redirect_valid  in  1  one-cycle pulse: change fetch stream
- redirect_pc  in  32  new fetch target; bits [1:0] used as given

Behaviour:
Reset (async, rst_n low):
- state=IDLE, pc_reg=RESET_PC, kill=0.
- arvalid=0, rready=0, out_valid=0, out_inst=0, out_pc=0.
- Reset mid-transaction drops everything immediately; no response is awaited after release.

States: IDLE, REQ, WAIT, HOLD. pc output = pc_reg in all states.
- IDLE: all outputs low. Next cycle -> REQ unconditionally.
- REQ: arvalid=1, rready=1.
  - arvalid && arready -> WAIT (the memory latches pc this cycle).
  - arvalid stays high until accepted; pc_reg is frozen.
- WAIT: arvalid=0, rready=1. On rvalid:
  - kill=0: out_inst<=inst, out_pc<=pc_reg, out_valid<=1, pc_reg<=pc_reg+32'd4 (mod 2^32, wraps from 32'hFFFF_FFFC to 0) -> HOLD.
  - kill=1: data discarded, pc_reg<=redir_q, kill<=0 -> REQ.
- HOLD: out_valid=1, out_inst and out_pc stable.
  - out_ready -> out_valid<=0 -> REQ.
  - Handshake to REQ is one-cycle registered; throughput is 1 inst per 3 cycles minimum with a zero-wait memory.

Redirect handling (redir_q = registered redirect_pc):
- IDLE or HOLD: pc_reg<=redirect_pc, out_valid<=0 -> REQ. Any held instruction is dropped.
  - HOLD with out_ready in the same cycle: the handshake counts as transferred; decode discards it. pc_reg still takes redirect_pc.
- REQ (before accept) or WAIT (before rvalid): kill<=1, redir_q<=redirect_pc. arvalid is not withdrawn.
  - In REQ: accepted normally, then WAIT resolves the kill.
- WAIT with rvalid in the same cycle: data discarded, pc_reg<=redirect_pc -> REQ.
- New redirect while kill=1: redir_q overwritten (latest wins).
- No combinational path from any input to any output.

Optional Feature:
- IFU_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[CNT_W-1:0] and perf_stall_cnt[CNT_W-1:0], both reset to 0.
  - perf_fetch_cnt: +1 per out_valid && out_ready.
  - perf_stall_cnt: +1 per cycle in REQ or WAIT.
  - Both wrap at 2^CNT_W.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, zero-wait memory (arready=1, rvalid 1 cycle after accept), out_ready=1 -> first pc=32'h8000_0000; out_pc sequence 8000_0000, 8000_0004, 8000_0008 with matching out_inst.
- Decode stall: out_ready=0 for 5 cycles in HOLD -> out_valid, out_inst, out_pc stable; no arvalid issued; PC resumes +4 after out_ready.
- Redirect to 32'h8000_0100 while in WAIT -> returned inst dropped (no out_valid); next arvalid carries pc=8000_0100.
- Redirect coincident with rvalid -> no out_valid; next REQ pc equals redirect_pc.
- Async reset asserted during WAIT -> all outputs 0 immediately; after release, fetch restarts at RESET_PC.
- IFU_PERF_CNT_EN: 10 instructions delivered with zero-wait memory -> perf_fetch_cnt=10, perf_stall_cnt=20.
